// File: rtl/dbg_commit_queue_if.sv
// rtl/dbg_commit_queue_if.sv - commit-record bus between WBU, queue and Dbg monitor
//
// Signals (direction as seen by the queue, modport slave):
//   in_valid   in   WBU offers a commit record
//   in_ready   out  queue accepts the offered record
//   in_rec     in   packed 182-bit commit record
//   step_en    in   debugger permits a pop this cycle
//   resume     in   one-cycle pulse that leaves HALT
//   out_done   out  one-cycle pulse, out_rec is newly retired
//   out_rec    out  last popped record, held between pops
//   out_gpr_wen/out_csr_wen/out_is_trap  out  strobes gated by out_done
//   halted     out  queue is in HALT
//   occupancy  out  entries held
//   retire_cnt out  number of out_done pulses, wrapping
interface dbg_commit_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [181:0]             in_rec;
  logic                     step_en;
  logic                     resume;
  logic                     out_done;
  logic [181:0]             out_rec;
  logic                     out_gpr_wen;
  logic                     out_csr_wen;
  logic                     out_is_trap;
  logic                     halted;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [63:0]              retire_cnt;

  modport slave (
    input  in_valid, in_rec, step_en, resume,
    output in_ready, out_done, out_rec, out_gpr_wen, out_csr_wen, out_is_trap,
           halted, occupancy, retire_cnt
  );

  modport master (
    output in_valid, in_rec, step_en, resume,
    input  in_ready, out_done, out_rec, out_gpr_wen, out_csr_wen, out_is_trap,
           halted, occupancy, retire_cnt
  );
endinterface

// File: rtl/dbg_commit_queue.sv
// rtl/dbg_commit_queue.sv - retire-side commit record queue feeding the Dbg monitor
//
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   bus    dbg_commit_queue_if.slave, push side from WBU and pop side to Dbg
// Record layout: pc[31:0] inst[63:32] gpr_wen[64] gpr_waddr[69:65] gpr_wdata[101:70]
//   csr_wen[102] csr_waddr[114:103] csr_wdata[146:115] is_trap[147] cause[179:148]
//   brk[180] ivd[181]
module dbg_commit_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dbg_commit_queue_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [181:0]  r_mem [DEPTH];
  logic          r_live;
  logic          r_out_done;
  logic [181:0]  r_out_rec;
  logic [63:0]   r_retire_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [181:0]  w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // r_live keeps in_ready low while in reset and for the edge that releases it.
  // A full queue never accepts, even when a pop frees a slot in the same cycle.
  assign bus.in_ready = r_live && !w_full && (r_state == ST_RUN);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = !w_empty && bus.step_en && (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_pop && (w_head[180] || w_head[181])) w_state_nxt = ST_HALT;
      ST_HALT: if (bus.resume) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_live       <= 1'b0;
      r_out_done   <= 1'b0;
      r_out_rec    <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_live     <= 1'b1;
      r_out_done <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_out_rec    <= w_head;
        r_retire_cnt <= r_retire_cnt + 64'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_rec;
  end

  assign bus.out_done    = r_out_done;
  assign bus.out_rec     = r_out_rec;
  // Writes to x0 are architecturally dropped, so they are never reported.
  assign bus.out_gpr_wen = r_out_done && r_out_rec[64] && (r_out_rec[69:65] != 5'd0);
  assign bus.out_csr_wen = r_out_done && r_out_rec[102];
  assign bus.out_is_trap = r_out_done && r_out_rec[147];
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.occupancy   = r_wr_ptr - r_rd_ptr;
  assign bus.retire_cnt  = r_retire_cnt;
endmodule

// File: tb/tb_dbg_commit_queue.sv
// tb/tb_dbg_commit_queue.sv - scoreboard bench for dbg_commit_queue
module tb_dbg_commit_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dbg_commit_queue_if #(.DEPTH(DEPTH)) bus ();
  dbg_commit_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  // Reference model: queue contents, expected retirements, halt flag, counter
  logic [181:0] m_q[$];
  logic [181:0] exp_q[$];
  logic         m_halt = 1'b0;
  logic         m_live = 1'b0;
  logic [63:0]  m_cnt = 64'd0;
  logic [181:0] m_last = '0;

  function automatic void chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [181:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic gw, input logic [4:0] ga, input logic [31:0] gd,
                                      input logic cw, input logic trap, input logic [31:0] cause,
                                      input logic brk, input logic ivd);
    logic [181:0] r;
    r = '0;
    r[31:0] = pc; r[63:32] = inst; r[64] = gw; r[69:65] = ga; r[101:70] = gd;
    r[102] = cw; r[114:103] = 12'h341; r[146:115] = 32'h1234;
    r[147] = trap; r[179:148] = cause; r[180] = brk; r[181] = ivd;
    return r;
  endfunction

  function automatic logic [181:0] rnd_rec(input bit allow_halt);
    logic [191:0] t;
    logic [181:0] r;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = t[181:0];
    if ($urandom_range(0, 3) == 0) r[69:65] = 5'd0;
    r[180] = allow_halt && ($urandom_range(0, 15) == 0);
    r[181] = allow_halt && ($urandom_range(0, 31) == 0);
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit pop, push, was_halt;
    logic [181:0] r;
    if (!reset) begin
      m_q.delete(); exp_q.delete();
      m_halt = 1'b0; m_live = 1'b0; m_cnt = 64'd0; m_last = '0;
    end else begin
      was_halt = m_halt;
      push = bus.in_valid && m_live && (m_q.size() < DEPTH) && !was_halt;
      pop  = (m_q.size() > 0) && bus.step_en && !was_halt;
      if (pop) begin
        r = m_q.pop_front();
        exp_q.push_back(r);
        m_last = r;
        m_cnt++;
        if (r[180] || r[181]) m_halt = 1'b1;
      end
      if (was_halt && bus.resume) m_halt = 1'b0;
      if (push) m_q.push_back(bus.in_rec);
      m_live = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [181:0] e;
    chk("in_ready", bus.in_ready, m_live && (m_q.size() < DEPTH) && !m_halt);
    chk("halted", bus.halted, m_halt);
    chk("occupancy", bus.occupancy, m_q.size());
    chk("retire_cnt", bus.retire_cnt, m_cnt);
    if (bus.out_done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done act=1 exp=0 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_rec", bus.out_rec, e);
        chk("gpr_wen", bus.out_gpr_wen, e[64] && (e[69:65] != 5'd0));
        chk("csr_wen", bus.out_csr_wen, e[102]);
        chk("is_trap", bus.out_is_trap, e[147]);
      end
    end else begin
      chk("missing_done", exp_q.size(), 0);
      chk("idle_strobes", {bus.out_gpr_wen, bus.out_csr_wen, bus.out_is_trap}, 3'b000);
      chk("rec_hold", bus.out_rec, m_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [181:0] r);
    bus.in_rec = r;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_rec = '0; bus.step_en = 1'b0; bus.resume = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // single retirement with GPR write to x1
    bus.step_en = 1'b1;
    push_one(mk(32'h80000000, 32'h00100093, 1'b1, 5'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
    repeat (3) tick();

    // fill beyond depth while stalled, then drain
    bus.step_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_rec = rnd_rec(1'b0);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.step_en = 1'b1;
    repeat (6) tick();

    // ebreak halts; queued entries wait for resume
    bus.step_en = 1'b0;
    push_one(mk(32'h80000004, 32'h00100073, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
    push_one(rnd_rec(1'b0));
    push_one(rnd_rec(1'b0));
    bus.step_en = 1'b1;
    repeat (12) tick();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    repeat (4) tick();

    // trap with CSR write, then x0 write
    push_one(mk(32'h80000010, 32'h00000073, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd11, 1'b0, 1'b0));
    push_one(mk(32'h80000014, 32'h00500013, 1'b1, 5'd0, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
    repeat (3) tick();

    // async reset mid-cycle while holding entries and presenting a pop
    bus.step_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(rnd_rec(1'b0));
    bus.step_en = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_out_done", bus.out_done, 1'b0);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_retire_cnt", bus.retire_cnt, 64'd0);
    chk("rst_out_rec", bus.out_rec, 182'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_rec   = rnd_rec(1'b1);
      bus.step_en  = ($urandom_range(0, 3) != 0);
      bus.resume   = ($urandom_range(0, 7) == 0);
      tick();
    end

    // drain everything
    bus.in_valid = 1'b0;
    bus.step_en = 1'b1;
    bus.resume = 1'b1;
    repeat (20) tick();
    bus.resume = 1'b0;
    tick();
    chk("drain_occupancy", bus.occupancy, 0);
    chk("drain_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
